spi_m_tx: RTL

SPI_M_TX -- requirements
Module: spi_m_tx

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_halfper_tick.sv | 37 +++
 rtl/spi_m_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding, bus mode and default timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   spi_m_state_t   - master transmitter FSM states
//   SPI_CPOL/CPHA   - bus mode (mode 0); SCK idles at SPI_CPOL
//   SPI_*_DEF       - default half-period divider and inter-frame idle length
package spi_pkg;

   // Mode 0: SCK idles low, data launched before the first (rising) edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   // 100 MHz core clock / (2 * 4) = 12.5 MHz SCK.
   localparam int SPI_CLK_DIV_DEF = 4;
   // Half-periods of nss high between frames.
   localparam int SPI_CS_IDLE_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_GAP      = 3'd3,
      ST_HOLD     = 3'd4,
      ST_DEASSERT = 3'd5
   } spi_m_state_t;

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV enabled cycles.
// Latency: tick asserts in the CLK_DIV-th enabled cycle after a clear/reload.
// Backpressure: none; holds its count while en is low.
//
// Ports:
//   clk, reset  - core clock, synchronous active-high reset
//   en          - count enable; tick is gated by it
//   clr         - synchronous clear back to 0 (priority over en)
//   tick        - high for the last cycle of each half-period
module spi_halfper_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Reload to 0 on every boundary so each state entered on a tick starts
   // its own half-period from a clean count.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_m_tx.sv
// SPI mode-0 master transmitter: bytes in over valid/ready, MSB first on MOSI.
// Latency: nss falls the cycle after acceptance; a lone byte keeps nss low 18*CLK_DIV cycles.
// Backpressure: o_tx_ready only in IDLE/GAP; valid while not ready is ignored.
//
// Ports:
//   i_clk, i_reset          - core clock, synchronous active-high reset
//   i_tx_data/_dataValid    - byte to send and its valid strobe
//   i_tx_last               - byte closes the frame (nss released afterwards)
//   o_tx_ready              - byte can be accepted this cycle
//   o_tx_done               - one-cycle pulse after a byte's last SCK low half
//   o_busy                  - FSM not in IDLE
//   o_spi_mosi/nss/clk      - SPI bus, all straight from flops
module spi_m_tx
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV_DEF,
   parameter int CS_IDLE = SPI_CS_IDLE_DEF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_dataValid,
   input  logic       i_tx_last,
   output logic       o_tx_ready,
   output logic       o_tx_done,
   output logic       o_busy,
   output logic       o_spi_mosi,
   output logic       o_spi_nss,
   output logic       o_spi_clk
);

   localparam logic [3:0] IDLE_LAST = 4'(CS_IDLE - 1);

   spi_m_state_t state;
   logic [7:0]   shreg;     // shreg[7] always mirrors the bit on MOSI
   logic [2:0]   bit_cnt;   // index of the bit currently on MOSI
   logic         last_r;    // captured i_tx_last of the byte in flight
   logic         fin_lo;    // in the final SCK-low half of the byte
   logic [3:0]   idle_cnt;  // half-periods spent in DEASSERT
   logic         tick;
   logic         tick_en;
   logic         accept;

   assign accept  = o_tx_ready && i_tx_dataValid;

   // The timer only runs in states with a fixed duration; IDLE and GAP wait
   // for the host, so SCK cannot advance there.
   assign tick_en = (state == ST_SETUP) || (state == ST_SHIFT) ||
                    (state == ST_HOLD)  || (state == ST_DEASSERT);

   spi_halfper_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (i_clk),
      .reset (i_reset),
      .en    (tick_en),
      .clr   (accept),
      .tick  (tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         last_r     <= 1'b0;
         fin_lo     <= 1'b0;
         idle_cnt   <= '0;
         o_tx_ready <= 1'b0;
         o_tx_done  <= 1'b0;
         o_busy     <= 1'b0;
         o_spi_mosi <= 1'b0;
         o_spi_nss  <= 1'b1;
         o_spi_clk  <= SPI_CPOL;
      end else begin
         o_tx_done <= 1'b0;

         case (state)
            // IDLE and GAP differ only in nss/mosi, which are simply held.
            ST_IDLE, ST_GAP: begin
               if (accept) begin
                  state      <= ST_SETUP;
                  o_tx_ready <= 1'b0;
                  o_busy     <= 1'b1;
                  o_spi_nss  <= 1'b0;
                  o_spi_clk  <= SPI_CPOL;
                  o_spi_mosi <= i_tx_data[7];
                  shreg      <= i_tx_data;
                  last_r     <= i_tx_last;
                  bit_cnt    <= 3'd7;
                  fin_lo     <= 1'b0;
               end else begin
                  o_tx_ready <= 1'b1;
               end
            end

            // bit7 already on MOSI; give the slave one half-period of setup.
            ST_SETUP: begin
               if (tick) begin
                  state     <= ST_SHIFT;
                  o_spi_clk <= ~SPI_CPOL;
               end
            end

            // sck high at a boundary means this boundary is a falling edge.
            // MOSI moves only on falling edges, so it is stable at every rise.
            ST_SHIFT: begin
               if (tick) begin
                  if (o_spi_clk != SPI_CPOL) begin
                     o_spi_clk <= SPI_CPOL;
                     if (bit_cnt == 3'd0) begin
                        // 8th fall: keep bit 0 on MOSI through the last low half.
                        fin_lo <= 1'b1;
                     end else begin
                        shreg      <= {shreg[6:0], 1'b0};
                        o_spi_mosi <= shreg[6];
                     end
                     // Wraps 0 -> 7; the next byte starts from 7 either way.
                     bit_cnt <= bit_cnt - 3'd1;
                  end else if (fin_lo) begin
                     fin_lo    <= 1'b0;
                     o_tx_done <= 1'b1;
                     if (last_r) begin
                        state <= ST_HOLD;
                     end else begin
                        state      <= ST_GAP;
                        o_tx_ready <= 1'b1;
                     end
                  end else begin
                     o_spi_clk <= ~SPI_CPOL;
                  end
               end
            end

            ST_HOLD: begin
               if (tick) begin
                  state      <= ST_DEASSERT;
                  o_spi_nss  <= 1'b1;
                  o_spi_mosi <= 1'b0;
                  idle_cnt   <= '0;
               end
            end

            // Ready stays low here so nss high time is never cut short.
            ST_DEASSERT: begin
               if (tick) begin
                  if (idle_cnt == IDLE_LAST) begin
                     state      <= ST_IDLE;
                     idle_cnt   <= '0;
                     o_busy     <= 1'b0;
                     o_tx_ready <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt + 4'd1;
                  end
               end
            end

            default: begin
               state      <= ST_IDLE;
               o_tx_ready <= 1'b0;
               o_busy     <= 1'b0;
               o_spi_nss  <= 1'b1;
               o_spi_clk  <= SPI_CPOL;
               o_spi_mosi <= 1'b0;
            end
         endcase
      end
   end

endmodule
